// File: rtl/checkpoint_mon_pkg.sv
// Shared types and constants for the checkpoint sequence monitor.
package checkpoint_mon_pkg;

    typedef enum logic [1:0] {
        IDLE,
        TRACK,
        DONE_PASS,
        DONE_FAIL
    } mon_state_e;

    localparam logic [1:0] FAIL_NONE       = 2'd0;
    localparam logic [1:0] FAIL_TIMEOUT    = 2'd1;
    localparam logic [1:0] FAIL_UNEXPECTED = 2'd2;

    localparam int MAX_STEPS = 8;

endpackage

// File: rtl/checkpoint_seq_monitor_filter.sv
// Two-flop synchroniser plus stability counter for the checkpoint bus.
// Emits a single acc_valid per newly settled value.
module stable_filter #(
    parameter int WIDTH         = 16,
    parameter int STABLE_CYCLES = 4
) (
    input  logic             clock,
    input  logic             resetb,
    input  logic [WIDTH-1:0] data_i,
    output logic             acc_valid_o,
    output logic [WIDTH-1:0] acc_value_o
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] TARGET = CW'(STABLE_CYCLES);

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic [WIDTH-1:0] prev_q;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic             fire_q;
    logic             fire_d;
    logic             changed;

    always_comb begin
        changed = (sync2_q != prev_q);
        cnt_d   = cnt_q;
        if (changed) begin
            cnt_d = CW'(1);
        end else if (cnt_q != TARGET) begin
            cnt_d = cnt_q + CW'(1);
        end
        // A saturated counter only fires again after a real change.
        fire_d = (cnt_d == TARGET) && (changed || cnt_q != TARGET);
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
            cnt_q   <= '0;
            fire_q  <= 1'b0;
        end else begin
            sync1_q <= data_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            cnt_q   <= cnt_d;
            fire_q  <= fire_d;
        end
    end

    assign acc_valid_o = fire_q;
    assign acc_value_o = prev_q;

endmodule

// File: rtl/checkpoint_seq_monitor.sv
// Matches debounced checkpoint values against a programmed sequence
// and reports pass/fail with a per-step timeout.
module checkpoint_seq_monitor
    import checkpoint_mon_pkg::*;
#(
    parameter int WIDTH          = 16,
    parameter int NUM_STEPS      = 3,
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 250000,
    parameter int STRICT         = 0
) (
    input  logic                       clock,
    input  logic                       resetb,
    input  logic                       start,
    input  logic [WIDTH-1:0]           checkbits,
    input  logic [NUM_STEPS*WIDTH-1:0] exp_seq,
    output logic                       busy,
    output logic                       pass,
    output logic                       fail,
    output logic [1:0]                 fail_code,
    output logic [2:0]                 step_idx,
    output logic                       step_pulse
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT_CYCLES);
    localparam logic [2:0] LAST = 3'(NUM_STEPS - 1);

    logic             acc_valid;
    logic [WIDTH-1:0] acc_value;
    logic [WIDTH-1:0] exp_arr [MAX_STEPS];

    mon_state_e state_q, state_d;
    logic [2:0]    step_q, step_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          pass_q, pass_d;
    logic          fail_q, fail_d;
    logic [1:0]    code_q, code_d;
    logic          pulse_q, pulse_d;
    logic          hit, held, bad;

    stable_filter #(
        .WIDTH         (WIDTH),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_filter (
        .clock       (clock),
        .resetb      (resetb),
        .data_i      (checkbits),
        .acc_valid_o (acc_valid),
        .acc_value_o (acc_value)
    );

    for (genvar k = 0; k < MAX_STEPS; k++) begin : g_exp
        if (k < NUM_STEPS) begin : g_used
            assign exp_arr[k] = exp_seq[k*WIDTH +: WIDTH];
        end else begin : g_pad
            assign exp_arr[k] = '0;
        end
    end

    always_comb begin
        hit  = acc_valid && (acc_value == exp_arr[step_q]);
        // The previous checkpoint may legitimately still be on the bus.
        held = acc_valid && (step_q != 3'd0)
            && (acc_value == exp_arr[step_q - 3'd1]);
        bad  = acc_valid && !hit && !held
            && (STRICT != 0) && (step_q != 3'd0);
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        timer_d = timer_q;
        pass_d  = pass_q;
        fail_d  = fail_q;
        code_d  = code_q;
        pulse_d = 1'b0;
        if (start) begin
            state_d = TRACK;
            step_d  = 3'd0;
            timer_d = '0;
            pass_d  = 1'b0;
            fail_d  = 1'b0;
            code_d  = FAIL_NONE;
        end else begin
            unique case (state_q)
                TRACK: begin
                    if (hit) begin
                        pulse_d = 1'b1;
                        timer_d = '0;
                        if (step_q == LAST) begin
                            state_d = DONE_PASS;
                            pass_d  = 1'b1;
                        end else begin
                            step_d = step_q + 3'd1;
                        end
                    end else if (timer_q == TO_LAST) begin
                        state_d = DONE_FAIL;
                        fail_d  = 1'b1;
                        code_d  = FAIL_TIMEOUT;
                    end else if (bad) begin
                        state_d = DONE_FAIL;
                        fail_d  = 1'b1;
                        code_d  = FAIL_UNEXPECTED;
                    end else if (timer_q != TO_MAX) begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                IDLE, DONE_PASS, DONE_FAIL: begin
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_q <= IDLE;
            step_q  <= 3'd0;
            timer_q <= '0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
            code_q  <= FAIL_NONE;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            timer_q <= timer_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            code_q  <= code_d;
            pulse_q <= pulse_d;
        end
    end

    assign busy       = (state_q == TRACK);
    assign pass       = pass_q;
    assign fail       = fail_q;
    assign fail_code  = code_q;
    assign step_idx   = step_q;
    assign step_pulse = pulse_q;

endmodule

// File: tb/tb_checkpoint_seq_monitor.sv
// Scoreboarded bench: a lenient and a strict monitor share one bus.
module tb_checkpoint_seq_monitor;

    logic        clock = 1'b0;
    logic        resetb = 1'b0;
    logic        start = 1'b0;
    logic [15:0] checkbits = 16'h0000;
    logic [47:0] exp_seq = {16'hAB51, 16'hAB41, 16'hAB40};

    logic       busy0, pass0, fail0, pulse0;
    logic [1:0] code0;
    logic [2:0] step0;
    logic       busy1, pass1, fail1, pulse1;
    logic [1:0] code1;
    logic [2:0] step1;

    int checks = 0;
    int failures = 0;
    int exp_q [$];
    logic [2:0] prev_step = 3'd0;

    always #5 clock = ~clock;

    checkpoint_seq_monitor #(
        .WIDTH(16), .NUM_STEPS(3), .STABLE_CYCLES(4),
        .TIMEOUT_CYCLES(100), .STRICT(0)
    ) dut (
        .clock(clock), .resetb(resetb), .start(start),
        .checkbits(checkbits), .exp_seq(exp_seq),
        .busy(busy0), .pass(pass0), .fail(fail0),
        .fail_code(code0), .step_idx(step0), .step_pulse(pulse0)
    );

    checkpoint_seq_monitor #(
        .WIDTH(16), .NUM_STEPS(3), .STABLE_CYCLES(4),
        .TIMEOUT_CYCLES(100), .STRICT(1)
    ) dut_s (
        .clock(clock), .resetb(resetb), .start(start),
        .checkbits(checkbits), .exp_seq(exp_seq),
        .busy(busy1), .pass(pass1), .fail(fail1),
        .fail_code(code1), .step_idx(step1), .step_pulse(pulse1)
    );

    // Scoreboard: each step_pulse must match the next expected step.
    always @(negedge clock) begin
        if (resetb && pulse0) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL pulse_sb: unexpected pulse at step %0d", prev_step);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (prev_step !== 3'(e) || fail0 !== 1'b0) begin
                    failures++;
                    $display("FAIL pulse_sb: got step %0d fail %0b, want step %0d fail 0",
                             prev_step, fail0, e);
                end
            end
        end
        prev_step = step0;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic hold(input logic [15:0] v, input int n);
        checkbits = v;
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic go_idle();
        hold(16'h0000, 10);
    endtask

    task automatic arm();
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        checkbits = 16'h0000;
        #12;
        checks++;
        if ({busy0, pass0, fail0, code0, step0, pulse0} !== 9'b0) begin
            failures++;
            $display("FAIL reset_lenient: got %b want 0",
                     {busy0, pass0, fail0, code0, step0, pulse0});
        end
        checks++;
        if ({busy1, pass1, fail1, code1, step1, pulse1} !== 9'b0) begin
            failures++;
            $display("FAIL reset_strict: got %b want 0",
                     {busy1, pass1, fail1, code1, step1, pulse1});
        end
        @(negedge clock);
        resetb = 1'b1;
        @(posedge clock);
        #1;
        go_idle();
    endtask

    task automatic test_happy();
        int n;
        go_idle();
        arm();
        checks++;
        if (busy0 !== 1'b1 || step0 !== 3'd0) begin
            failures++;
            $display("FAIL happy_arm: busy %0b step %0d want 1 0", busy0, step0);
        end
        exp_q.push_back(0);
        exp_q.push_back(1);
        exp_q.push_back(2);
        hold(16'hAB40, 10);
        hold(16'hAB41, 10);
        checkbits = 16'hAB51;
        n = 0;
        while (pass0 !== 1'b1 && n < 20) begin
            @(posedge clock);
            #1;
            n++;
        end
        checks++;
        if (n !== 7) begin
            failures++;
            $display("FAIL happy_latency: got %0d cycles want 7", n);
        end
        checks++;
        if ({pass0, fail0, code0, busy0, step0} !== {1'b1, 1'b0, 2'd0, 1'b0, 3'd2}) begin
            failures++;
            $display("FAIL happy_final: p%0b f%0b c%0d b%0b s%0d want p1 f0 c0 b0 s2",
                     pass0, fail0, code0, busy0, step0);
        end
        checks++;
        if (pass1 !== 1'b1 || fail1 !== 1'b0) begin
            failures++;
            $display("FAIL happy_strict: pass %0b fail %0b want 1 0", pass1, fail1);
        end
    endtask

    task automatic test_glitch();
        go_idle();
        arm();
        exp_q.push_back(0);
        hold(16'hAB40, 10);
        hold(16'hAB41, 3);
        hold(16'hAB40, 10);
        checks++;
        if (step0 !== 3'd1 || busy0 !== 1'b1) begin
            failures++;
            $display("FAIL glitch_lenient: step %0d busy %0b want 1 1", step0, busy0);
        end
        checks++;
        if (step1 !== 3'd1 || busy1 !== 1'b1 || fail1 !== 1'b0) begin
            failures++;
            $display("FAIL glitch_strict: step %0d busy %0b fail %0b want 1 1 0",
                     step1, busy1, fail1);
        end
    endtask

    task automatic test_timeout();
        int n;
        go_idle();
        arm();
        exp_q.push_back(0);
        checkbits = 16'hAB40;
        n = 0;
        while (pulse0 !== 1'b1 && n < 20) begin
            @(posedge clock);
            #1;
            n++;
        end
        checks++;
        if (pulse0 !== 1'b1) begin
            failures++;
            $display("FAIL timeout_step0: no pulse after %0d cycles", n);
        end
        n = 0;
        while (fail0 !== 1'b1 && n < 150) begin
            @(posedge clock);
            #1;
            n++;
        end
        checks++;
        if (n !== 100) begin
            failures++;
            $display("FAIL timeout_cycles: got %0d want 100", n);
        end
        checks++;
        if ({fail0, code0, step0, pass0, busy0} !== {1'b1, 2'd1, 3'd1, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL timeout_final: f%0b c%0d s%0d p%0b b%0b want f1 c1 s1 p0 b0",
                     fail0, code0, step0, pass0, busy0);
        end
        checks++;
        if (fail1 !== 1'b1 || code1 !== 2'd1) begin
            failures++;
            $display("FAIL timeout_strict: fail %0b code %0d want 1 1", fail1, code1);
        end
    endtask

    task automatic test_strict();
        int n;
        go_idle();
        arm();
        exp_q.push_back(0);
        hold(16'hAB40, 10);
        checkbits = 16'h1234;
        n = 0;
        while (fail1 !== 1'b1 && n < 20) begin
            @(posedge clock);
            #1;
            n++;
        end
        checks++;
        if ({fail1, code1, step1, pass1} !== {1'b1, 2'd2, 3'd1, 1'b0}) begin
            failures++;
            $display("FAIL strict_final: f%0b c%0d s%0d p%0b want f1 c2 s1 p0",
                     fail1, code1, step1, pass1);
        end
        hold(16'h1234, 10);
        checks++;
        if (busy0 !== 1'b1 || fail0 !== 1'b0 || step0 !== 3'd1) begin
            failures++;
            $display("FAIL strict_lenient: busy %0b fail %0b step %0d want 1 0 1",
                     busy0, fail0, step0);
        end
    endtask

    task automatic test_back_to_back();
        go_idle();
        arm();
        exp_q.push_back(0);
        exp_q.push_back(1);
        hold(16'hAB40, 10);
        hold(16'hAB41, 10);
        checks++;
        if (step0 !== 3'd2) begin
            failures++;
            $display("FAIL restart_pre: step %0d want 2", step0);
        end
        arm();
        checks++;
        if ({step0, busy0, pass0, fail0} !== {3'd0, 1'b1, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL restart_arm: s%0d b%0b p%0b f%0b want s0 b1 p0 f0",
                     step0, busy0, pass0, fail0);
        end
        exp_q.push_back(0);
        exp_q.push_back(1);
        exp_q.push_back(2);
        hold(16'hAB40, 10);
        hold(16'hAB41, 10);
        hold(16'hAB51, 10);
        checks++;
        if ({pass0, fail0, code0, step0} !== {1'b1, 1'b0, 2'd0, 3'd2}) begin
            failures++;
            $display("FAIL restart_final: p%0b f%0b c%0d s%0d want p1 f0 c0 s2",
                     pass0, fail0, code0, step0);
        end
    endtask

    task automatic test_async_reset();
        go_idle();
        arm();
        exp_q.push_back(0);
        hold(16'hAB40, 10);
        #3;
        resetb = 1'b0;
        #0.5;
        checks++;
        if ({busy0, pass0, fail0, code0, step0, pulse0} !== 9'b0) begin
            failures++;
            $display("FAIL areset_now: got %b want 0",
                     {busy0, pass0, fail0, code0, step0, pulse0});
        end
        #0.5;
        resetb = 1'b1;
        @(posedge clock);
        #1;
        hold(16'hAB40, 10);
        checks++;
        if ({busy0, pass0, fail0, step0} !== 6'b0) begin
            failures++;
            $display("FAIL areset_after: b%0b p%0b f%0b s%0d want idle zeros",
                     busy0, pass0, fail0, step0);
        end
    endtask

    initial begin
        test_reset();
        test_happy();
        test_glitch();
        test_timeout();
        test_strict();
        test_back_to_back();
        test_async_reset();
        checks++;
        if (exp_q.size() !== 0) begin
            failures++;
            $display("FAIL sb_drain: %0d pulses missing, want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
